// File: rtl/dtw_traceback_pkg.sv
// rtl/dtw_traceback_pkg.sv - shared path codes, sizes and FSM encoding for the DTW traceback
package dtw_traceback_pkg;

  // Default index width: sequences up to 64 samples, memory addressed by {i,j}
  localparam int DTW_IDX_W  = 6;
  localparam int DTW_ADDR_W = 2 * DTW_IDX_W;

  // Path codes as emitted by the PE array: bit1 steps the row, bit0 steps the column
  localparam logic [1:0] PATH_DIAG = 2'b11;
  localparam logic [1:0] PATH_UP   = 2'b10;
  localparam logic [1:0] PATH_LEFT = 2'b01;
  localparam logic [1:0] PATH_RST  = 2'b00;

  // Traceback controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_EMIT = 3'd3,
    ST_FIN  = 3'd4,
    ST_ERR  = 3'd5
  } tb_state_t;

endpackage

// File: rtl/dtw_traceback_if.sv
// rtl/dtw_traceback_if.sv - warping path pair stream between traceback and alignment logic
interface dtw_traceback_if
  import dtw_traceback_pkg::*;
#(
  parameter int IDX_W = DTW_IDX_W
);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_i;
  logic [IDX_W-1:0] out_j;
  logic             out_last;

  // Producer side (traceback)
  modport master (
    output out_valid,
    output out_i,
    output out_j,
    output out_last,
    input  out_ready
  );

  // Consumer side (alignment output logic)
  modport slave (
    input  out_valid,
    input  out_i,
    input  out_j,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/dtw_path_ram.sv
// rtl/dtw_path_ram.sv - simple dual-port path code memory with registered read
module dtw_path_ram
  import dtw_traceback_pkg::*;
#(
  parameter int ADDR_W = DTW_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data
);

  logic [1:0] mem [2**ADDR_W];
  logic [1:0] rd_data_q;
  logic [1:0] rd_data_d;

  // Write port: contents are deliberately not reset, unwritten cells read back as whatever was left
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data holds its last value unless a new read is issued
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Registered read: data appears the cycle after rd_en
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dtw_traceback.sv
// rtl/dtw_traceback.sv - walks stored DTW path codes back from the end cell and streams the path
module dtw_traceback
  import dtw_traceback_pkg::*;
#(
  parameter int IDX_W  = DTW_IDX_W,
  parameter int ADDR_W = 2 * IDX_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_i,
  input  logic [IDX_W-1:0] wr_j,
  input  logic [1:0]       wr_path,
  input  logic             start,
  input  logic [IDX_W-1:0] len_i,
  input  logic [IDX_W-1:0] len_j,
  output logic             busy,
  output logic             done,
  output logic             err,
  dtw_traceback_if.master  out_if
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  tb_state_t        state_q, state_d;
  logic [IDX_W-1:0] ci_q, ci_d;
  logic [IDX_W-1:0] cj_q, cj_d;
  logic [IDX_W-1:0] ni_q, ni_d;
  logic [IDX_W-1:0] nj_q, nj_d;
  logic [IDX_W-1:0] step_i;
  logic [IDX_W-1:0] step_j;

  logic             ram_we;
  logic             rd_en;
  logic [1:0]       rd_code;
  logic             at_origin;
  logic             interior;
  logic             emit;

  assign at_origin = (ci_q == '0) && (cj_q == '0);
  assign interior  = (ci_q != '0) && (cj_q != '0);

  // The path memory belongs to the PE array while idle; once walking, its writes are dropped
  assign ram_we = wr_en && (state_q == ST_IDLE);

  dtw_path_ram #(
    .ADDR_W (ADDR_W)
  ) u_path_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr ({wr_i, wr_j}),
    .wr_data (wr_path),
    .rd_en   (rd_en),
    .rd_addr ({ci_q, cj_q}),
    .rd_data (rd_code)
  );

  // Predecessor of the current cell; on row 0 / column 0 the code is ignored so indices never wrap
  always_comb begin
    step_i = ci_q;
    step_j = cj_q;
    if (interior) begin
      unique case (rd_code)
        PATH_DIAG: begin
          step_i = ci_q - IDX_ONE;
          step_j = cj_q - IDX_ONE;
        end
        PATH_UP:   step_i = ci_q - IDX_ONE;
        PATH_LEFT: step_j = cj_q - IDX_ONE;
        default:   ;
      endcase
    end else if (ci_q != '0) begin
      step_i = ci_q - IDX_ONE;
    end else if (cj_q != '0) begin
      step_j = cj_q - IDX_ONE;
    end
  end

  // Controller: read the cell, check/step its code, present the pair, repeat until (0,0)
  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    cj_d    = cj_q;
    ni_d    = ni_q;
    nj_d    = nj_q;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ci_d    = len_i;
          cj_d    = len_j;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        rd_en   = 1'b1;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (interior && (rd_code == PATH_RST)) begin
          state_d = ST_ERR;
        end else begin
          ni_d    = step_i;
          nj_d    = step_j;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_if.out_ready) begin
          if (at_origin) begin
            state_d = ST_FIN;
          end else begin
            ci_d    = ni_q;
            cj_d    = nj_q;
            state_d = ST_RD;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and index registers; reset abandons any walk in flight without signalling done
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      ci_q    <= '0;
      cj_q    <= '0;
      ni_q    <= '0;
      nj_q    <= '0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      cj_q    <= cj_d;
      ni_q    <= ni_d;
      nj_q    <= nj_d;
    end
  end

  assign emit = (state_q == ST_EMIT);

  assign out_if.out_valid = emit;
  assign out_if.out_i     = emit ? ci_q : '0;
  assign out_if.out_j     = emit ? cj_q : '0;
  assign out_if.out_last  = emit && at_origin;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN) || (state_q == ST_ERR);
  assign err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_dtw_traceback.sv
// tb/tb_dtw_traceback.sv - directed bench with path-walk reference model for dtw_traceback
module tb_dtw_traceback;

  typedef struct {
    int i;
    int j;
    bit last;
  } pair_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic       wr_en;
  logic [5:0] wr_i, wr_j;
  logic [1:0] wr_path;
  logic       start;
  logic [5:0] len_i, len_j;
  logic       busy, done, err;

  dtw_traceback_if #(.IDX_W(6)) out_if ();

  dtw_traceback dut (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (wr_en),
    .wr_i    (wr_i),
    .wr_j    (wr_j),
    .wr_path (wr_path),
    .start   (start),
    .len_i   (len_i),
    .len_j   (len_j),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .out_if  (out_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_stall = 0;
  int n_done = 0;

  logic [1:0] shadow [0:4095];
  pair_t      exp_q[$];
  bit         exp_err;

  int hold_i = -1;
  int hold_j = -1;
  int hold_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference walk: follow the stored codes from the end cell, bit1 = row step, bit0 = column step
  function automatic void build_expect(input int li, input int lj);
    int    i, j;
    pair_t p;
    logic [1:0] code;
    exp_q.delete();
    exp_err = 1'b0;
    i = li;
    j = lj;
    for (int n = 0; n < 200; n++) begin
      if (i != 0 && j != 0 && shadow[i*64+j] == 2'b00) begin
        exp_err = 1'b1;
        break;
      end
      p.i = i;
      p.j = j;
      p.last = (i == 0 && j == 0);
      exp_q.push_back(p);
      if (p.last) break;
      if (i == 0) j--;
      else if (j == 0) i--;
      else begin
        code = shadow[i*64+j];
        if (code[1]) i--;
        if (code[0]) j--;
      end
    end
  endfunction

  // Stream scoreboard: every valid pair must be the model's next one, done must land on an empty queue
  always @(negedge clk) begin
    if (nrst) begin
      if (out_if.out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pair: got (%0d,%0d), expected no pair", out_if.out_i, out_if.out_j);
        end else begin
          check("pair_i", int'(out_if.out_i), exp_q[0].i);
          check("pair_j", int'(out_if.out_j), exp_q[0].j);
          check("pair_last", int'(out_if.out_last), int'(exp_q[0].last));
          if (out_if.out_ready) begin
            void'(exp_q.pop_front());
            n_acc++;
          end else begin
            n_stall++;
          end
        end
      end
      if (done) begin
        check("err_at_done", int'(err), int'(exp_err));
        check("pairs_left_at_done", exp_q.size(), 0);
        n_done++;
      end else if (err) begin
        check("err_without_done", int'(err), 0);
      end
    end
  end

  // Consumer: ready high except for a programmed stall on one chosen pair
  initial begin
    out_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_if.out_valid && int'(out_if.out_i) == hold_i && int'(out_if.out_j) == hold_j && hold_cnt > 0) begin
        out_if.out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_if.out_ready = 1'b1;
      end
    end
  end

  task automatic write_cell(input int i, input int j, input logic [1:0] code, input bit track);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_i    = 6'(i);
    wr_j    = 6'(j);
    wr_path = code;
    if (track) shadow[i*64+j] = code;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic fill_diag4();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        write_cell(i, j, 2'b11, 1'b1);
  endtask

  task automatic start_trace(input int li, input int lj);
    build_expect(li, lj);
    @(posedge clk);
    #1;
    start = 1'b1;
    len_i = 6'(li);
    len_j = 6'(lj);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk);
    check({tag, "_busy_t1"}, int'(busy), 1);
    check({tag, "_valid_t1"}, int'(out_if.out_valid), 0);
    @(negedge clk);
    check({tag, "_valid_t2"}, int'(out_if.out_valid), 0);
    @(negedge clk);
    check({tag, "_valid_t3"}, int'(out_if.out_valid), 1);
  endtask

  task automatic wait_done(input string tag, output int cycles);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) break;
    end
    cycles = k;
    if (k == 400) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done, expected done within 400 cycles", tag);
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    int k;

    for (int a = 0; a < 4096; a++) shadow[a] = 2'b00;
    nrst = 1'b0;
    wr_en = 1'b0; wr_i = '0; wr_j = '0; wr_path = '0;
    start = 1'b0; len_i = '0; len_j = '0;
    exp_err = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_valid", int'(out_if.out_valid), 0);
    check("rst_last", int'(out_if.out_last), 0);
    check("rst_i", int'(out_if.out_i), 0);
    check("rst_j", int'(out_if.out_j), 0);
    @(posedge clk);
    #2;
    nrst = 1'b1;

    // 1: full diagonal 3,3
    fill_diag4();
    start_trace(3, 3);
    check("model_t1_len", exp_q.size(), 4);
    check("model_t1_last_i", exp_q[3].i, 0);
    check("model_t1_last_j", exp_q[3].j, 0);
    check("model_t1_2nd_i", exp_q[1].i, 2);
    check_latency("t1");
    wait_done("t1", cyc);

    // 2: column edge, codes ignored
    start_trace(2, 0);
    check("model_t2_len", exp_q.size(), 3);
    check("model_t2_2nd_i", exp_q[1].i, 1);
    wait_done("t2", cyc);

    // 3: mixed codes with a 5-cycle stall on (1,2)
    write_cell(2, 2, 2'b10, 1'b1);
    write_cell(1, 2, 2'b01, 1'b1);
    write_cell(1, 1, 2'b11, 1'b1);
    base = n_stall;
    hold_i = 1; hold_j = 2; hold_cnt = 5;
    start_trace(2, 2);
    check("model_t3_len", exp_q.size(), 4);
    check("model_t3_2nd_i", exp_q[1].i, 1);
    check("model_t3_2nd_j", exp_q[1].j, 2);
    check("model_t3_3rd_j", exp_q[2].j, 1);
    wait_done("t3", cyc);
    check("t3_stall_cycles", n_stall - base, 5);
    hold_i = -1; hold_j = -1;

    // 4: illegal code on interior cell
    write_cell(2, 2, 2'b11, 1'b1);
    write_cell(1, 1, 2'b00, 1'b1);
    base = n_done;
    start_trace(2, 2);
    check("model_t4_err", int'(exp_err), 1);
    check("model_t4_len", exp_q.size(), 1);
    wait_done("t4", cyc);
    check("t4_done_seen", n_done - base, 1);

    // 5: async reset mid-stream, then restart with writes and start while busy
    fill_diag4();
    base = n_acc;
    start_trace(3, 3);
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      if (n_acc >= base + 2) break;
    end
    check("t5_two_pairs_before_abort", int'(n_acc >= base + 2), 1);
    #2;
    nrst = 1'b0;
    #1;
    check("abort_valid", int'(out_if.out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    check("abort_i", int'(out_if.out_i), 0);
    check("abort_j", int'(out_if.out_j), 0);
    check("abort_last", int'(out_if.out_last), 0);
    exp_q.delete();
    exp_err = 1'b0;
    base = n_done;
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b1;
    start_trace(3, 3);
    write_cell(2, 2, 2'b01, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1; len_i = 6'd1; len_j = 6'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5", cyc);
    check("t5_one_done_after_restart", n_done - base, 1);
    start_trace(2, 2);
    check("model_t5b_len", exp_q.size(), 3);
    wait_done("t5b", cyc);

    // 6: degenerate 0,0
    start_trace(0, 0);
    check("model_t6_len", exp_q.size(), 1);
    check("model_t6_last", int'(exp_q[0].last), 1);
    check_latency("t6");
    check("t6_last_flag", int'(out_if.out_last), 1);
    wait_done("t6", cyc);
    check("t6_done_next_cycle", cyc, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
